// File: rtl/adc_ovfl_monitor.sv
// Per-channel ADC overflow counter over a programmable sample window.
// Flags a channel when its count reaches the threshold and tracks the peak count per window.
module adc_ovfl_monitor #(
    parameter int unsigned NCH      = 1,
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned SEL_BITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [NCH-1:0]      ovfl_in,
    input  logic                cfg_wr,
    input  logic                cfg_sel,
    input  logic [CNT_BITS-1:0] cfg_data,
    input  logic                clr,
    output logic [NCH-1:0]      ovfl_pulse,
    output logic [NCH-1:0]      ovfl_sticky,
    output logic                any_ovfl,
    input  logic [SEL_BITS-1:0] peak_sel,
    output logic [CNT_BITS:0]   peak_cnt
);

    localparam int unsigned CW = CNT_BITS + 1;
    typedef logic [CW-1:0] cnt_t;

    logic [CNT_BITS-1:0] r_win_len, r_thresh, r_win_cnt;
    logic [CNT_BITS-1:0] w_win_len_d, w_thresh_d, w_win_cnt_d;
    cnt_t                r_cnt   [NCH];
    cnt_t                r_peak  [NCH];
    cnt_t                w_cnt_d [NCH];
    cnt_t                w_peak_d[NCH];
    cnt_t                w_final [NCH];
    cnt_t                w_thr_cmp;
    logic [NCH-1:0]      r_pulse, r_sticky, w_pulse_d, w_sticky_d;
    logic                w_len_wr, w_thr_wr, w_terminal, w_eval;

    always_comb begin
        w_len_wr    = cfg_wr & ~cfg_sel;
        w_thr_wr    = cfg_wr & cfg_sel;
        w_terminal  = sample_en & (r_win_cnt == r_win_len);
        // A window-length write discards the window, even on its terminal sample.
        w_eval      = w_terminal & ~w_len_wr;
        w_thr_cmp   = {1'b0, r_thresh};
        w_win_len_d = w_len_wr ? cfg_data : r_win_len;
        w_thresh_d  = w_thr_wr ? cfg_data : r_thresh;
        w_win_cnt_d = r_win_cnt;
        if (w_len_wr || w_terminal) begin
            w_win_cnt_d = '0;
        end else if (sample_en) begin
            w_win_cnt_d = r_win_cnt + CNT_BITS'(1);
        end
        for (int i = 0; i < NCH; i++) begin
            w_final[i] = r_cnt[i] + cnt_t'(ovfl_in[i]);
            w_cnt_d[i] = r_cnt[i];
            if (w_len_wr || w_terminal) begin
                w_cnt_d[i] = '0;
            end else if (sample_en) begin
                w_cnt_d[i] = w_final[i];
            end
            w_pulse_d[i]  = w_eval && (r_thresh != '0) && (w_final[i] >= w_thr_cmp);
            // A coincident evaluation overrides clr.
            w_sticky_d[i] = (r_sticky[i] & ~clr) | w_pulse_d[i];
            w_peak_d[i]   = clr ? '0 : r_peak[i];
            if (w_eval && (w_final[i] > w_peak_d[i])) begin
                w_peak_d[i] = w_final[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_len <= '1;
            r_thresh  <= CNT_BITS'(1);
            r_win_cnt <= '0;
            r_pulse   <= '0;
            r_sticky  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]  <= '0;
                r_peak[i] <= '0;
            end
        end else begin
            r_win_len <= w_win_len_d;
            r_thresh  <= w_thresh_d;
            r_win_cnt <= w_win_cnt_d;
            r_pulse   <= w_pulse_d;
            r_sticky  <= w_sticky_d;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]  <= w_cnt_d[i];
                r_peak[i] <= w_peak_d[i];
            end
        end
    end

    always_comb begin
        ovfl_pulse  = r_pulse;
        ovfl_sticky = r_sticky;
        any_ovfl    = |r_sticky;
        peak_cnt    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (peak_sel == SEL_BITS'(i)) begin
                peak_cnt = r_peak[i];
            end
        end
    end

endmodule

// File: tb/tb_adc_ovfl_monitor.sv
// Scoreboard bench for adc_ovfl_monitor with NCH=2, CNT_BITS=4 (16-sample default window).
module tb_adc_ovfl_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [1:0] ovfl_in = '0;
    logic       cfg_wr = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [3:0] cfg_data = '0;
    logic       clr = 1'b0;
    logic [1:0] peak_sel = '0;
    logic [1:0] ovfl_pulse, ovfl_sticky;
    logic       any_ovfl;
    logic [4:0] peak_cnt;

    adc_ovfl_monitor #(.NCH(2), .CNT_BITS(4), .SEL_BITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .ovfl_in    (ovfl_in),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .clr        (clr),
        .ovfl_pulse (ovfl_pulse),
        .ovfl_sticky(ovfl_sticky),
        .any_ovfl   (any_ovfl),
        .peak_sel   (peak_sel),
        .peak_cnt   (peak_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pulse;
        logic [1:0] sticky;
        logic [4:0] pk0;
        logic [4:0] pk1;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: window length in samples, samples seen so far, raw counts.
    int         m_len, m_thr, m_n;
    int         m_cnt [2];
    int         m_peak[2];
    logic [1:0] m_sticky;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_len = 16;
        m_thr = 1;
        m_n = 0;
        m_sticky = '0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_peak[i] = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic [1:0] ov, input logic wr,
                              input logic sel, input logic [3:0] data, input logic cl,
                              output exp_t e);
        logic lw, term, ev;
        int   fin;
        e = '0;
        lw = wr && !sel;
        term = en && (m_n + 1 == m_len);
        ev = term && !lw;
        if (cl) begin
            m_sticky = '0;
            m_peak[0] = 0;
            m_peak[1] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            fin = m_cnt[i] + int'(ov[i]);
            if (ev) begin
                if (m_thr != 0 && fin >= m_thr) e.pulse[i] = 1'b1;
                if (fin > m_peak[i]) m_peak[i] = fin;
            end
        end
        m_sticky = m_sticky | e.pulse;
        if (lw || term) begin
            m_n = 0;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if (en) begin
            m_n++;
            m_cnt[0] += int'(ov[0]);
            m_cnt[1] += int'(ov[1]);
        end
        if (wr) begin
            if (sel) m_thr = int'(data);
            else m_len = int'(data) + 1;
        end
        e.sticky = m_sticky;
        e.pk0 = 5'(m_peak[0]);
        e.pk1 = 5'(m_peak[1]);
    endtask

    task automatic step(input string tag, input logic en, input logic [1:0] ov, input logic wr,
                        input logic sel, input logic [3:0] data, input logic cl);
        exp_t e;
        logic [4:0] epk;
        sample_en = en;
        ovfl_in = ov;
        cfg_wr = wr;
        cfg_sel = sel;
        cfg_data = data;
        clr = cl;
        model_step(en, ov, wr, sel, data, cl, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        ovfl_in = '0;
        cfg_wr = 1'b0;
        clr = 1'b0;
        e = sb_q.pop_front();
        epk = (peak_sel == 2'd0) ? e.pk0 : (peak_sel == 2'd1) ? e.pk1 : 5'd0;
        check_eq({tag, "_pulse"}, 32'(ovfl_pulse), 32'(e.pulse));
        check_eq({tag, "_sticky"}, 32'(ovfl_sticky), 32'(e.sticky));
        check_eq({tag, "_any"}, 32'(any_ovfl), 32'(|e.sticky));
        check_eq({tag, "_peak"}, 32'(peak_cnt), 32'(epk));
    endtask

    task automatic samp(input string tag, input logic [1:0] ov);
        step(tag, 1'b1, ov, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic cfg(input string tag, input logic sel, input logic [3:0] data);
        step(tag, 1'b0, 2'b00, 1'b1, sel, data, 1'b0);
    endtask

    task automatic do_clr(input string tag);
        step(tag, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", {ovfl_pulse, ovfl_sticky, any_ovfl, peak_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default 16-sample window, one overflow on ch0 at sample 5
        for (int k = 0; k < 16; k++) samp("t1", (k == 5) ? 2'b01 : 2'b00);
        peak_sel = 2'd1;
        idle("t1_sel1");
        peak_sel = 2'd2;
        idle("t1_sel2");
        peak_sel = 2'd0;

        // Window 4, threshold 4 on ch1
        do_clr("t2_clr");
        cfg("t2_len", 1'b0, 4'd3);
        cfg("t2_thr", 1'b1, 4'd4);
        for (int k = 0; k < 4; k++) samp("t2_w1", 2'b10);
        for (int k = 0; k < 4; k++) samp("t2_w2", (k < 3) ? 2'b10 : 2'b00);
        peak_sel = 2'd1;
        idle("t2_peak");
        peak_sel = 2'd0;

        // Full 16-sample window of overflows must reach 16 without wrapping
        do_clr("t3_clr");
        cfg("t3_len", 1'b0, 4'd15);
        cfg("t3_thr", 1'b1, 4'd15);
        for (int k = 0; k < 16; k++) samp("t3", 2'b01);
        idle("t3_peak");

        // Sparse sample_en; unqualified overflows ignored
        do_clr("t4_clr");
        cfg("t4_len", 1'b0, 4'd3);
        cfg("t4_thr", 1'b1, 4'd1);
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 2) step("t4_q", 1'b1, (k == 5) ? 2'b01 : 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
            else step("t4_u", 1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        end

        // clr coincident with window end, then idle clr
        samp("t5", 2'b01);
        samp("t5", 2'b01);
        samp("t5", 2'b00);
        step("t5_clr_eval", 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        do_clr("t5_clr_idle");

        // Window-length write mid-window discards the partial window
        for (int k = 0; k < 3; k++) samp("t6_pre", 2'b01);
        cfg("t6_len", 1'b0, 4'd7);
        for (int k = 0; k < 8; k++) samp("t6", 2'b01);

        // Threshold 0: no pulses, peaks still tracked
        cfg("t7_thr0", 1'b1, 4'd0);
        for (int k = 0; k < 8; k++) samp("t7", 2'b11);
        peak_sel = 2'd1;
        idle("t7_peak1");
        peak_sel = 2'd0;

        // Window length 1: every sample evaluated
        cfg("t8_len", 1'b0, 4'd0);
        cfg("t8_thr", 1'b1, 4'd1);
        samp("t8", 2'b01);
        samp("t8", 2'b10);
        samp("t8", 2'b11);
        samp("t8", 2'b00);

        // Random mix of samples, short-window configs, clears and peak selects
        for (int k = 0; k < 400; k++) begin
            peak_sel = 2'($urandom_range(0, 3));
            step("rnd", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
        end
        peak_sel = 2'd0;

        // Async reset mid-window with sticky set
        cfg("t9_len", 1'b0, 4'd0);
        cfg("t9_thr", 1'b1, 4'd1);
        samp("t9_set", 2'b11);
        cfg("t9_len4", 1'b0, 4'd3);
        samp("t9_mid", 2'b01);
        samp("t9_mid", 2'b01);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {ovfl_pulse, ovfl_sticky, any_ovfl, peak_cnt}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First window after reset is the default 16 samples
        for (int k = 0; k < 16; k++) samp("t10", (k == 15) ? 2'b10 : 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_ovfl_monitor.md
Name: adc_ovfl_monitor

Overview:
- Parametrised successor to the single-channel, fixed 64k-sample ADC overflow detector in the SDR top level.
- Counts ADC overflow assertions per channel over a programmable sample window and compares each count to a programmable threshold.
- Produces per-window pulses, sticky per-channel flags and a peak-count readback.
- Sits in the ADC clock domain between the ADC front end(s) and the existing SYNC_PULSE crossing into the CPU status path.

Parameters:
NCH, 1, number of ADC channels monitored (1..8)
CNT_BITS, 16, window-length/count field width; max window 2^CNT_BITS samples
SEL_BITS, 3, width of peak channel select (must satisfy 2^SEL_BITS >= NCH)

Ports:
clk  in  1  ADC sample clock; single clock for the whole block
rst_n  in  1  asynchronous active-low reset
sample_en  in  1  qualifies one sample on all channels this cycle
ovfl_in  in  NCH  per-channel raw ADC overflow bit, valid when sample_en=1
cfg_wr  in  1  one-cycle configuration write strobe
cfg_sel  in  1  0 = window-length register, 1 = threshold register
cfg_data  in  CNT_BITS  configuration write data
clr  in  1  one-cycle clear of sticky flags and peak registers
ovfl_pulse  out  NCH  one-cycle pulse per channel at window end when count >= threshold
ovfl_sticky  out  NCH  per-channel latched overflow flag
any_ovfl  out  1  OR of ovfl_sticky
peak_sel  in  SEL_BITS  channel select for peak_cnt
peak_cnt  out  CNT_BITS+1  largest completed-window count on selected channel since last clr

Behaviour:
- Reset (rst_n=0, asynchronous):
  - win_len_reg = 2^CNT_BITS-1 (window 2^CNT_BITS samples); thresh_reg = 1.
  - Window counter, all channel counts, ovfl_pulse, ovfl_sticky, any_ovfl and peak registers = 0.
- Window length = win_len_reg+1, range 1..2^CNT_BITS. Channel counts are CNT_BITS+1 wide so a full window of overflows never wraps.
- Each sample_en cycle:
  - If the window counter != win_len_reg: the counter increments and each channel count adds ovfl_in[i].
  - If the window counter == win_len_reg (terminal sample): the final count is cnt[i]+ovfl_in[i]. The terminal sample is included, giving exactly win_len_reg+1 samples per window.
  - On the terminal sample the counter and counts reset to 0 on the next edge.
- Window-end evaluation, registered on the edge that ends the window (1-cycle latency after the terminal sample):
  - ovfl_pulse[i] = (thresh_reg != 0) && (final[i] >= thresh_reg); deasserted next cycle.
  - ovfl_sticky[i] is set if ovfl_pulse[i] is set.
  - peak[i] <= max(peak[i], final[i]).
- thresh_reg = 0 disables pulse and sticky generation; peaks still update.
- sample_en=0: all counters hold; ovfl_in is ignored.
- cfg_wr:
  - Writes the selected register on the next edge.
  - A window-length write also zeroes the window counter and all channel counts. The partial window is discarded with no evaluation.
  - A threshold write takes effect from the next window-end evaluation; the current window is not restarted.
  - If cfg_wr coincides with a terminal sample, the evaluation uses the old threshold. On a window-length write the counters restart from 0 and the terminal sample is not counted.
- clr:
  - Zeroes ovfl_sticky and all peaks on the next edge.
  - If clr coincides with a window-end evaluation, the new evaluation wins: sticky is set and peak = final.
  - clr does not disturb the window counter or counts.
- any_ovfl is combinational OR of the registered ovfl_sticky (same-cycle as sticky).
- peak_cnt is a combinational mux of peak[peak_sel]. A peak_sel >= NCH returns 0.
- Reset mid-window discards all state; the first window after reset release starts at the first sample_en.
- Window length 1: every sample is evaluated; final = ovfl_in. A pulse may occur every sample_en cycle.

Test Plan:
- Reset default, NCH=2, CNT_BITS=4 (window 16), thresh=1; ch0 ovfl high on sample 5 only -> ovfl_pulse[0] one cycle after sample 15, sticky[0]=1, any_ovfl=1, peak_cnt(sel 0)=1, ch1 silent.
- Window length 4, thresh 4; ch1 ovfl high for all 4 samples of window 1 and 3 of 4 in window 2 -> pulse once after window 1, none after window 2; peak[1]=4.
- Full-window boundary, CNT_BITS=4, window 16, all 16 samples overflowing, thresh 15 -> final count 16 (no wrap), pulse asserted, peak_cnt=16.
- sample_en gaps: window 4 with sample_en every 3rd cycle -> evaluation only after the 4th qualified sample; ovfl_in asserted on unqualified cycles is not counted.
- clr coincident with window-end evaluation (count 2, thresh 1) -> sticky remains 1, peak=2; clr in an idle cycle afterwards -> sticky=0, peak=0.
- Window-length write mid-window after 3 overflowing samples (set window 8) -> no evaluation for the discarded window; the next pulse requires a fresh 8 samples. Threshold write of 0 -> no further pulses while peaks still update; rst_n low mid-window clears all outputs asynchronously.
